nrd16by8: RTL and testbench
===========================

NRD16BY8 -- requirements
Module: nrd16by8

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at a 16-bit dividend and an 8-bit divisor.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, signed 16 bits: two's-complement dividend (e.g. a multiplier product).
REQ-006 The block SHALL have port divisor, input, signed 8 bits: two's-complement divisor.
REQ-007 The block SHALL have port quotient, output, signed 16 bits: truncated-toward-zero quotient.
REQ-008 The block SHALL have port remainder, output, signed 8 bits: remainder, sign equal to dividend sign (0 if exact).
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when quotient/remainder/flags become valid.
REQ-011 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag for the current result.
REQ-012 The block SHALL have port ovf, output, 1 bit: quotient-not-representable flag (only -32768 / -1).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, SIGN; the reset state SHALL be IDLE.
REQ-014 In IDLE with start=1 at edge E, the block SHALL capture dividend and divisor, store |dividend| (16-bit unsigned) and |divisor| (8-bit unsigned), store both sign bits, clear the iteration counter, set busy=1, and enter RUN.
REQ-015 In RUN, the block SHALL perform one non-restoring division step per cycle (shift the partial remainder left, then add or subtract |divisor| according to the partial-remainder sign, producing one quotient bit), for exactly 16 cycles (edges E+1..E+16).
REQ-016 The partial remainder SHALL be at least 10 bits signed so that no intermediate step overflows.
REQ-017 At edge E+17 (SIGN), the block SHALL apply the final remainder correction (add |divisor| if the partial remainder is negative).
REQ-018 At edge E+17, the block SHALL negate the quotient if the dividend and divisor signs differ, and negate the remainder if the dividend is negative.
REQ-019 At edge E+17, the block SHALL register quotient, remainder, dbz, and ovf, assert done=1, deassert busy, and return to IDLE.
REQ-020 Latency SHALL be fixed: done is high in the cycle following edge E+17 and for that cycle only.
REQ-021 If divisor==0 at the start edge E, the block SHALL skip RUN and go directly to SIGN.
REQ-022 For divide-by-zero, the result at edge E+1 SHALL be: quotient=0, remainder=0, dbz=1, ovf=0, done pulse.
REQ-023 For -32768 / -1, the block SHALL produce quotient=16'h8000, remainder=0, ovf=1, dbz=0, with normal latency.
REQ-024 start SHALL be ignored while busy=1; the operand registers SHALL NOT change during RUN or SIGN.
REQ-025 start=1 in the same cycle that done=1 (FSM already in IDLE) SHALL be accepted as a new division.
REQ-026 quotient, remainder, dbz, and ovf SHALL hold their last values until the next SIGN update.
REQ-027 A held-high start SHALL launch back-to-back divisions, one every 18 cycles.

Reset
REQ-028 While rst=1, outputs SHALL be: quotient=0, remainder=0, busy=0, done=0, dbz=0, ovf=0; FSM=IDLE; counter=0.
REQ-029 rst asserted mid-RUN or in SIGN SHALL abort the division immediately, with no done pulse and no output update.
REQ-030 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover: dividend=-8343, divisor=-81, start pulse -> done 17 cycles after the start edge, quotient=103, remainder=0, dbz=0, ovf=0.
REQ-032 The bench SHALL cover: dividend=-11639, divisor=113 -> quotient=-103, remainder=0; then dividend=100, divisor=7 -> quotient=14, remainder=2; then -100/7 -> quotient=-14, remainder=-2.
REQ-033 The bench SHALL cover: divisor=0, dividend=1234 -> done 1 cycle after the start edge, dbz=1, quotient=0, remainder=0.
REQ-034 The bench SHALL cover: dividend=-32768, divisor=-1 -> quotient=16'h8000, remainder=0, ovf=1; and -32768/1 -> quotient=16'h8000, ovf=0.
REQ-035 The bench SHALL cover: a second start pulse at cycle 5 of RUN -> ignored, with a single done pulse for the first operands only.
REQ-036 The bench SHALL cover: rst pulse at cycle 8 of RUN -> all outputs 0, busy=0, no done pulse; a following start with 50/-7 -> quotient=-7, remainder=1.

Source files
------------

// File: rtl/nrd16by8.sv
// Sequential signed 16/8 divider: non-restoring, one quotient bit per cycle,
// truncating toward zero with remainder carrying the dividend's sign.
module nrd16by8 (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] dividend,
  input  logic signed [7:0]  divisor,
  output logic signed [15:0] quotient,
  output logic signed [7:0]  remainder,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic               ovf
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // RUN   | 16 non-restoring steps, one quotient bit each
  // SIGN  | remainder correction, sign fix-up, publish results
  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  pr_q, pr_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  dvs_q, dvs_d;
  logic        sdd_q, sdd_d;
  logic        sdv_q, sdv_d;
  logic        ovfc_q, ovfc_d;
  logic [15:0] quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [9:0]  pr_sh, pr_new, pr_fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    sdd_d   = sdd_q;
    sdv_d   = sdv_q;
    ovfc_d  = ovfc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    pr_sh   = {pr_q[8:0], q_q[15]};
    pr_new  = pr_q[9] ? (pr_sh + {2'b00, dvs_q}) : (pr_sh - {2'b00, dvs_q});
    pr_fix  = pr_q[9] ? (pr_q + {2'b00, dvs_q}) : pr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend[15] ? -dividend : dividend;
          dvs_d   = divisor[7] ? -divisor : divisor;
          sdd_d   = dividend[15];
          sdv_d   = divisor[7];
          // -32768 / -1 is the only quotient that cannot be represented
          ovfc_d  = dividend[15] && (dividend[14:0] == 15'd0) && (&divisor);
          pr_d    = 10'd0;
          cnt_d   = 4'd0;
          state_d = (divisor == 8'sd0) ? SIGN : RUN;
        end
      end
      RUN: begin
        pr_d  = pr_new;
        q_d   = {q_q[14:0], ~pr_new[9]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = SIGN;
      end
      SIGN: begin
        if (dvs_q == 8'd0) begin
          quo_d = 16'd0;
          rem_d = 8'd0;
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else begin
          quo_d = (sdd_q ^ sdv_q) ? -q_q : q_q;
          rem_d = sdd_q ? -pr_fix[7:0] : pr_fix[7:0];
          dbz_d = 1'b0;
          ovf_d = ovfc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pr_q    <= 10'd0;
      q_q     <= 16'd0;
      dvs_q   <= 8'd0;
      sdd_q   <= 1'b0;
      sdv_q   <= 1'b0;
      ovfc_q  <= 1'b0;
      quo_q   <= 16'd0;
      rem_q   <= 8'd0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      sdd_q   <= sdd_d;
      sdv_q   <= sdv_d;
      ovfc_q  <= ovfc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nrd16by8.sv
// Bench for nrd16by8: vector table plus scoreboard queue checked on each done pulse.
module tb_nrd16by8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] dividend;
  logic signed [7:0]  divisor;
  logic signed [15:0] quotient;
  logic signed [7:0]  remainder;
  logic               busy, done, dbz, ovf;

  nrd16by8 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .dbz(dbz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] dd;
    logic signed [7:0]  dv;
    int                 q;
    int                 r;
    bit                 dbz;
    bit                 ovf;
    int                 lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t sb[$];
  vec_t tbl[9];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle", cycle, e.cyc);
        chk("quotient", int'(quotient), e.v.q);
        chk("remainder", int'(remainder), e.v.r);
        chk("dbz", int'(dbz), int'(e.v.dbz));
        chk("ovf", int'(ovf), int'(e.v.ovf));
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic launch(input vec_t v);
    exp_t e;
    @(negedge clk);
    dividend = v.dd;
    divisor  = v.dv;
    start    = 1'b1;
    e.v   = v;
    e.cyc = cycle + 1 + v.lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input int dd, input int dv, input int q, input int r,
                              input bit z, input bit o, input int lat);
    vec_t v;
    v.dd = 16'(dd); v.dv = 8'(dv); v.q = q; v.r = r; v.dbz = z; v.ovf = o; v.lat = lat;
    return v;
  endfunction

  initial begin
    vec_t v;
    tbl[0] = mk(-8343, -81, 103, 0, 0, 0, 17);
    tbl[1] = mk(-11639, 113, -103, 0, 0, 0, 17);
    tbl[2] = mk(100, 7, 14, 2, 0, 0, 17);
    tbl[3] = mk(-100, 7, -14, -2, 0, 0, 17);
    tbl[4] = mk(1234, 0, 0, 0, 1, 0, 1);
    tbl[5] = mk(32767, 127, 258, 1, 0, 0, 17);
    tbl[6] = mk(1000, -128, -7, 104, 0, 0, 17);
    tbl[7] = mk(-32768, 1, -32768, 0, 0, 0, 17);
    tbl[8] = mk(-32768, -1, -32768, 0, 0, 1, 17);

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      launch(tbl[i]);
      wait_empty(40);
    end

    // abort mid-RUN: the pending entry is dropped, and any later done is spurious
    launch(mk(1000, 3, 333, 1, 0, 0, 17));
    repeat (7) @(negedge clk);
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_dbz", int'(dbz), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    launch(mk(50, -7, -7, 1, 0, 0, 17));
    wait_empty(40);

    // start during RUN must be ignored
    launch(mk(1000, 7, 142, 6, 0, 0, 17));
    repeat (4) @(negedge clk);
    dividend = 16'sd2000; divisor = 8'sd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_run", int'(busy), 1);
    wait_empty(40);
    repeat (20) @(negedge clk);

    // held start: back-to-back launches 18 cycles apart
    v = mk(-100, 7, -14, -2, 0, 0, 17);
    @(negedge clk);
    dividend = v.dd; divisor = v.dv; start = 1'b1;
    begin
      exp_t e;
      e.v = v; e.cyc = cycle + 18; sb.push_back(e);
      e.cyc = cycle + 36; sb.push_back(e);
    end
    repeat (19) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_empty(60);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
